// File: rtl/trap_pkg.sv
// +------------------------------------------------------------------------+
// | Package     : trap_pkg                                                 |
// | Description : CSR addresses, cause codes, request kinds, FSM states.   |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
`default_nettype none

package trap_pkg;

    localparam logic [11:0] c_CSR_MSTATUS = 12'h300;
    localparam logic [11:0] c_CSR_MTVEC   = 12'h305;
    localparam logic [11:0] c_CSR_MEPC    = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] c_CAUSE_ECALL_M    = 32'h0000_000B;
    localparam logic [31:0] c_CAUSE_BREAKPOINT = 32'h0000_0003;
    localparam logic [31:0] c_CAUSE_MTIMER_IRQ = 32'h8000_0007;

    localparam logic [1:0] c_KIND_RSVD   = 2'b00;
    localparam logic [1:0] c_KIND_ECALL  = 2'b01;
    localparam logic [1:0] c_KIND_MRET   = 2'b10;
    localparam logic [1:0] c_KIND_EBREAK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SAVE_EPC   = 3'd1,
        S_SAVE_CAUSE = 3'd2,
        S_RD_VEC     = 3'd3,
        S_RD_EPC     = 3'd4,
        S_REDIRECT   = 3'd5
    } state_t;

    // MRET and the reserved kind carry no cause value.
    function automatic logic [31:0] cause_of(input logic [1:0] kind);
        case (kind)
            c_KIND_ECALL:  return c_CAUSE_ECALL_M;
            c_KIND_EBREAK: return c_CAUSE_BREAKPOINT;
            default:       return 32'h0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/trap_ctrl.sv
// +------------------------------------------------------------------------+
// | Module      : trap_ctrl                                                |
// | Description : Sequences mepc/mcause writes and the mtvec/mepc redirect |
// |               for ECALL, EBREAK and MRET. Optional interrupt entry is  |
// |               enabled by defining TRAP_CTRL_IRQ_EN.                    |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
`default_nettype none

module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic [1:0]        trap_kind,
    input  logic [XLEN-1:0]   trap_pc,
    output logic              csr_wen,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic [CSR_AW-1:0] csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [XLEN-1:0]   redir_pc,
    output logic              busy
`ifdef TRAP_CTRL_IRQ_EN
    ,
    input  logic              irq_pending,
    input  logic              irq_enable,
    input  logic [XLEN-1:0]   irq_pc,
    output logic              irq_ack
`endif
);

    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_redir_pc;
    logic            w_idle;
    logic            w_accept_trap;
    logic            w_accept_irq;

    assign w_idle        = (r_state == S_IDLE);
    assign trap_ready    = w_idle && !rst;
    assign w_accept_trap = trap_valid && trap_ready;
    assign busy          = !w_idle;
    assign redir_pc      = r_redir_pc;

`ifdef TRAP_CTRL_IRQ_EN
    // A synchronous trap request always wins over a pending interrupt.
    assign w_accept_irq = trap_ready && irq_pending && irq_enable && !trap_valid;
    assign irq_ack      = w_accept_irq;
`else
    assign w_accept_irq = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_cause    <= '0;
            r_redir_pc <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept_trap) begin
                r_pc    <= trap_pc;
                r_cause <= XLEN'(cause_of(trap_kind));
            end
`ifdef TRAP_CTRL_IRQ_EN
            else if (w_accept_irq) begin
                r_pc    <= irq_pc;
                r_cause <= XLEN'(c_CAUSE_MTIMER_IRQ);
            end
`endif
            // Direct mode only: the low mode bits of mtvec are dropped.
            if (r_state == S_RD_VEC || r_state == S_RD_EPC) begin
                r_redir_pc <= csr_rdata & c_ALIGN_MASK;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        csr_wen     = 1'b0;
        csr_waddr   = '0;
        csr_wdata   = '0;
        csr_raddr   = '0;
        redir_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept_trap) begin
                    case (trap_kind)
                        c_KIND_ECALL, c_KIND_EBREAK: w_next = S_SAVE_EPC;
                        c_KIND_MRET:                 w_next = S_RD_EPC;
                        default:                     w_next = S_IDLE;
                    endcase
                end else if (w_accept_irq) begin
                    w_next = S_SAVE_EPC;
                end
            end
            S_SAVE_EPC: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_AW'(c_CSR_MEPC);
                csr_wdata = r_pc & c_ALIGN_MASK;
                w_next    = S_SAVE_CAUSE;
            end
            S_SAVE_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_AW'(c_CSR_MCAUSE);
                csr_wdata = r_cause;
                w_next    = S_RD_VEC;
            end
            S_RD_VEC: begin
                csr_raddr = CSR_AW'(c_CSR_MTVEC);
                w_next    = S_REDIRECT;
            end
            S_RD_EPC: begin
                csr_raddr = CSR_AW'(c_CSR_MEPC);
                w_next    = S_REDIRECT;
            end
            S_REDIRECT: begin
                redir_valid = 1'b1;
                if (redir_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// +------------------------------------------------------------------------+
// | Module      : tb_trap_ctrl                                             |
// | Description : Self-checking bench for trap_ctrl with a CSR file model  |
// |               and write/redirect scoreboards.                          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_trap_ctrl;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid;
    logic        trap_ready;
    logic [1:0]  trap_kind;
    logic [31:0] trap_pc;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        busy;
`ifdef TRAP_CTRL_IRQ_EN
    logic        irq_pending;
    logic        irq_enable;
    logic [31:0] irq_pc;
    logic        irq_ack;
`endif

    logic [31:0] mtvec  = '0;
    logic [31:0] mepc   = '0;
    logic [31:0] mcause = '0;
    logic        pre_en;
    logic [11:0] pre_a;
    logic [31:0] pre_d;

    wr_t         exp_wr[$];
    logic [31:0] exp_redir[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;
    int          seen;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .trap_valid  (trap_valid),
        .trap_ready  (trap_ready),
        .trap_kind   (trap_kind),
        .trap_pc     (trap_pc),
        .csr_wen     (csr_wen),
        .csr_waddr   (csr_waddr),
        .csr_wdata   (csr_wdata),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc),
        .busy        (busy)
`ifdef TRAP_CTRL_IRQ_EN
        ,
        .irq_pending (irq_pending),
        .irq_enable  (irq_enable),
        .irq_pc      (irq_pc),
        .irq_ack     (irq_ack)
`endif
    );

    // CSR file model: DUT writes take priority over bench presets.
    always @(posedge clk) begin
        if (csr_wen) begin
            case (csr_waddr)
                12'h305: mtvec  <= csr_wdata;
                12'h341: mepc   <= csr_wdata;
                12'h342: mcause <= csr_wdata;
                default: ;
            endcase
        end else if (pre_en) begin
            case (pre_a)
                12'h305: mtvec  <= pre_d;
                12'h341: mepc   <= pre_d;
                12'h342: mcause <= pre_d;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (csr_raddr)
            12'h305: csr_rdata = mtvec;
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            default: csr_rdata = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe and redirect handshake pops one entry.
    always @(negedge clk) begin
        if (csr_wen) begin
            check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_addr", 32'(csr_waddr), 32'(e.a));
                check("wr_data", csr_wdata, e.d);
            end
        end
        if (redir_valid && redir_ready) begin
            check("redir_expected", 32'(exp_redir.size() != 0), 32'd1);
            if (exp_redir.size() != 0) begin
                check("redir_pc", redir_pc, exp_redir.pop_front());
            end
        end
    end

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
        pre_en = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Presents a request in IDLE; returns 1ns after the accept edge with garbage inputs.
    task automatic accept(input logic [1:0] kind, input logic [31:0] pc);
        trap_valid = 1'b1;
        trap_kind  = kind;
        trap_pc    = pc;
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        trap_kind  = 2'b11;
        trap_pc    = 32'hFFFF_FFFF;
    endtask

    // Counts clock edges after the accept edge until redir_valid; -1 on timeout.
    task automatic wait_redir(output int l);
        l = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (redir_valid) begin
                l = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; trap_valid = 1'b0; trap_kind = 2'b00; trap_pc = '0;
        redir_ready = 1'b0; pre_en = 1'b0; pre_a = '0; pre_d = '0;
`ifdef TRAP_CTRL_IRQ_EN
        irq_pending = 1'b0; irq_enable = 1'b0; irq_pc = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_trap_ready", 32'(trap_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_redir_valid", 32'(redir_valid), 32'd0);
        check("rst_redir_pc", redir_pc, 32'h0);
        check("rst_csr_wen", 32'(csr_wen), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_trap_ready", 32'(trap_ready), 32'd1);

        // ECALL
        set_csr(12'h305, 32'h8000_1001);
        redir_ready = 1'b1;
        push_wr(12'h341, 32'h8000_0104);
        push_wr(12'h342, 32'h0000_000B);
        exp_redir.push_back(32'h8000_1000);
        accept(2'b01, 32'h8000_0104);
        wait_redir(lat);
        check("ecall_latency", 32'(lat), 32'd3);
        check("ecall_redir_pc", redir_pc, 32'h8000_1000);
        @(posedge clk);
        @(negedge clk);
        check("ecall_ready_after", 32'(trap_ready), 32'd1);
        check("ecall_mepc", mepc, 32'h8000_0104);
        check("ecall_mcause", mcause, 32'h0000_000B);

        // MRET
        set_csr(12'h341, 32'h8000_0106);
        exp_redir.push_back(32'h8000_0104);
        accept(2'b10, 32'h1234_5678);
        wait_redir(lat);
        check("mret_latency", 32'(lat), 32'd1);
        check("mret_redir_pc", redir_pc, 32'h8000_0104);
        @(posedge clk);
        @(negedge clk);
        check("mret_idle", 32'(busy), 32'd0);

        // EBREAK with a stalled IFU and a second request held during the stall
        redir_ready = 1'b0;
        push_wr(12'h341, 32'h8000_0200);
        push_wr(12'h342, 32'h0000_0003);
        exp_redir.push_back(32'h8000_1000);
        accept(2'b11, 32'h8000_0203);
        wait_redir(lat);
        check("ebreak_latency", 32'(lat), 32'd3);
        trap_valid = 1'b1;
        trap_kind  = 2'b01;
        trap_pc    = 32'h8000_0300;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(redir_valid), 32'd1);
            check("stall_pc", redir_pc, 32'h8000_1000);
            check("stall_ready", 32'(trap_ready), 32'd0);
        end
        check("ebreak_mcause", mcause, 32'h0000_0003);
        push_wr(12'h341, 32'h8000_0300);
        push_wr(12'h342, 32'h0000_000B);
        exp_redir.push_back(32'h8000_1000);
        @(posedge clk);
        #1 redir_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("held_req_idle", 32'(trap_ready), 32'd1);
        @(posedge clk);
        #1 trap_valid = 1'b0;
        wait_redir(lat);
        check("held_req_latency", 32'(lat), 32'd3);
        @(posedge clk);
        #1;

        // Reset while in SAVE_CAUSE
        set_csr(12'h342, 32'hDEAD_BEEF);
        push_wr(12'h341, 32'h8000_0400);
        accept(2'b01, 32'h8000_0400);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_wen", 32'(csr_wen), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(trap_ready), 32'd0);
        check("abort_redir", 32'(redir_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (redir_valid || csr_wen) seen++;
        end
        check("abort_quiet", 32'(seen), 32'd0);
        check("abort_mepc", mepc, 32'h8000_0400);
        check("abort_mcause", mcause, 32'hDEAD_BEEF);

        // Reserved kind
        trap_valid = 1'b1;
        trap_kind  = 2'b00;
        trap_pc    = 32'h8000_0500;
        @(negedge clk);
        check("rsvd_ready_pre", 32'(trap_ready), 32'd1);
        @(posedge clk);
        #1 trap_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rsvd_ready", 32'(trap_ready), 32'd1);
            check("rsvd_busy", 32'(busy), 32'd0);
            check("rsvd_wen", 32'(csr_wen), 32'd0);
            check("rsvd_redir", 32'(redir_valid), 32'd0);
        end

`ifdef TRAP_CTRL_IRQ_EN
        // Interrupt arriving together with an ECALL
        irq_pending = 1'b1;
        irq_enable  = 1'b1;
        irq_pc      = 32'h8000_0200;
        trap_valid  = 1'b1;
        trap_kind   = 2'b01;
        trap_pc     = 32'h8000_0500;
        push_wr(12'h341, 32'h8000_0500);
        push_wr(12'h342, 32'h0000_000B);
        exp_redir.push_back(32'h8000_1000);
        push_wr(12'h341, 32'h8000_0200);
        push_wr(12'h342, 32'h8000_0007);
        exp_redir.push_back(32'h8000_1000);
        @(negedge clk);
        check("irq_ack_trap_wins", 32'(irq_ack), 32'd0);
        @(posedge clk);
        #1 trap_valid = 1'b0;
        wait_redir(lat);
        check("irq_ecall_latency", 32'(lat), 32'd3);
        @(posedge clk);
        @(negedge clk);
        check("irq_ack_pulse", 32'(irq_ack), 32'd1);
        @(posedge clk);
        #1 irq_pending = 1'b0;
        wait_redir(lat);
        check("irq_latency", 32'(lat), 32'd3);
        @(posedge clk);
        @(negedge clk);
        check("irq_ack_low", 32'(irq_ack), 32'd0);
        check("irq_mepc", mepc, 32'h8000_0200);
        check("irq_mcause", mcause, 32'h8000_0007);
`endif

        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("redir_queue_empty", 32'(exp_redir.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
